// File: rtl/pkt_reader.sv
// Packet buffer read engine: fetches a length header and payload words, streams them out through a FIFO.
// Optional statistics outputs (pkt_count, byte_count) when PKT_READER_STATS_EN is defined.
module pkt_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_ctrl,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_ctrl_rdy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef PKT_READER_STATS_EN
  ,
  output logic [31:0]       pkt_count,
  output logic [31:0]       byte_count
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [LEN_W-1:0] ceil_words(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(BYTES - 1);
    return LEN_W'(sum >> BSH);
  endfunction

  logic [2:0]        state_q, state_d;
  logic              hdr_ph_q, hdr_ph_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rdv_q, rdv_d;
  logic              rdy_q, rdy_d;
  logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]  pop_idx_q, pop_idx_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  nwords_q, nwords_d;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [LEN_W-1:0]  len_in;
  logic [CW:0]       occ;
  logic              room, abort, push, pop;

  assign len_in    = mem_rdata[LEN_W-1:0];
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign out_last  = out_valid && (pop_idx_q == nwords_q - LEN_W'(1));
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign rd_ctrl_rdy = rdy_q;

  // Reserve FIFO space for every read still in the two-cycle memory pipeline
  assign occ   = {1'b0, count_q} + {{CW{1'b0}}, mem_rd_q} + {{CW{1'b0}}, rdv_q};
  assign room  = occ < (CW+1)'(FIFO_DEPTH);
  assign abort = !rd_ctrl && (state_q == S_HDR || state_q == S_READ || state_q == S_DRAIN);
  assign push  = rdv_q;
  assign pop   = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    hdr_ph_d   = hdr_ph_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    rdv_d      = mem_rd_q && (state_q == S_READ || state_q == S_DRAIN);
    rd_idx_d   = rd_idx_q;
    base_d     = base_q;
    nwords_d   = nwords_q;
    case (state_q)
      S_IDLE: if (rd_ctrl) begin
        state_d    = S_HDR;
        hdr_ph_d   = 1'b0;
        mem_rd_d   = 1'b1;
        mem_addr_d = base_addr;
        base_d     = base_addr;
        rd_idx_d   = '0;
      end
      S_HDR: begin
        if (!hdr_ph_q) begin
          hdr_ph_d = 1'b1;
        end else begin
          nwords_d = ceil_words(len_in);
          state_d  = (len_in == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: if (rd_idx_q < nwords_q && room) begin
        mem_rd_d   = 1'b1;
        mem_addr_d = base_q + ADDR_W'(rd_idx_q) + ADDR_W'(1);
        rd_idx_d   = rd_idx_q + LEN_W'(1);
        if (rd_idx_q + LEN_W'(1) == nwords_q) state_d = S_DRAIN;
      end
      S_DRAIN: if (count_q == '0 && !mem_rd_q && !rdv_q) state_d = S_DONE;
      S_DONE:  if (!rd_ctrl) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      mem_rd_d = 1'b0;
      rdv_d    = 1'b0;
    end
    rdy_d = (state_d == S_DONE);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_idx_d = pop_idx_q;
    if (abort || (state_q == S_IDLE)) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pop_idx_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        pop_idx_d = pop_idx_q + LEN_W'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hdr_ph_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      rdv_q      <= 1'b0;
      rdy_q      <= 1'b0;
      rd_idx_q   <= '0;
      pop_idx_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      hdr_ph_q   <= hdr_ph_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      rdv_q      <= rdv_d;
      rdy_q      <= rdy_d;
      rd_idx_q   <= rd_idx_d;
      pop_idx_q  <= pop_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Datapath storage carries no reset; validity comes from the control flops
  always_ff @(posedge clk) begin
    base_q   <= base_d;
    nwords_q <= nwords_d;
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
  end

`ifdef PKT_READER_STATS_EN
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      pkt_count_q, pkt_count_d, byte_count_q, byte_count_d;

  always_comb begin
    len_d        = (state_q == S_HDR && hdr_ph_q) ? len_in : len_q;
    pkt_count_d  = pkt_count_q;
    byte_count_d = byte_count_q;
    if (state_d == S_DONE && state_q != S_DONE) begin
      pkt_count_d  = pkt_count_q + 32'd1;
      byte_count_d = byte_count_q + 32'(len_d);
    end
  end

  always_ff @(posedge clk) begin
    len_q <= len_d;
    if (reset) begin
      pkt_count_q  <= '0;
      byte_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_pkt_reader.sv
// Directed bench for pkt_reader: buffer RAM model, transfer monitor, hand-computed expectations.
module tb_pkt_reader;
  logic        clk = 1'b0;
  logic        reset, rd_ctrl, out_ready;
  logic [9:0]  base_addr;
  logic        rd_ctrl_rdy, mem_rd, out_valid, out_last;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] out_data;
`ifdef PKT_READER_STATS_EN
  logic [31:0] pkt_count, byte_count;
`endif

  pkt_reader dut (
    .clk(clk), .reset(reset), .rd_ctrl(rd_ctrl), .base_addr(base_addr),
    .rd_ctrl_rdy(rd_ctrl_rdy), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
`ifdef PKT_READER_STATS_EN
    , .pkt_count(pkt_count), .byte_count(byte_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 | 32'(a & 1023);
  endfunction

  int          cyc_n = 0;
  logic [9:0]  addr_log[$];
  logic [31:0] data_log[$];
  logic        last_log[$];
  int          wcyc_log[$];

  always @(negedge clk) begin
    cyc_n++;
    if (mem_rd) addr_log.push_back(mem_addr);
    if (out_valid && out_ready) begin
      data_log.push_back(out_data);
      last_log.push_back(out_last);
      wcyc_log.push_back(cyc_n);
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    last_log.delete();
    wcyc_log.delete();
  endtask

  task automatic start_pkt(input logic [9:0] base, input int len);
    clear_logs();
    mem[base] = 32'(len);
    base_addr = base;
    rd_ctrl   = 1'b1;
  endtask

  task automatic finish_pkt(input int budget);
    int k;
    k = 0;
    while (!rd_ctrl_rdy && k < budget) begin
      tick();
      k++;
    end
    chk("rdy_seen", rd_ctrl_rdy, 1);
    tick();
    tick();
    chk("rdy_held", rd_ctrl_rdy, 1);
    rd_ctrl = 1'b0;
    tick();
    chk("rdy_drop", rd_ctrl_rdy, 0);
  endtask

  task automatic run_pkt(input logic [9:0] base, input int len, input int budget);
    start_pkt(base, len);
    finish_pkt(budget);
  endtask

  task automatic check_addrs(input logic [9:0] base, input int nw);
    chk("addr_count", addr_log.size(), nw + 1);
    for (int j = 0; j < addr_log.size() && j <= nw; j++)
      chk($sformatf("addr%0d", j), addr_log[j], 10'(base + j));
  endtask

  task automatic check_words(input logic [9:0] base, input int nw);
    chk("word_count", data_log.size(), nw);
    for (int j = 0; j < data_log.size() && j < nw; j++) begin
      chk($sformatf("data%0d", j), data_log[j], pat(int'(base) + 1 + j));
      chk($sformatf("last%0d", j), last_log[j], (j == nw - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, hits;
    for (int i = 0; i < 1024; i++) mem[i] = pat(i);
    reset = 1'b1; rd_ctrl = 1'b0; out_ready = 1'b1; base_addr = '0;
    repeat (3) tick();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rdy", rd_ctrl_rdy, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", out_data, 0);
    reset = 1'b0;
    tick();

    // Basic packet: 10 bytes -> 3 words
    run_pkt(10'h020, 10, 50);
    check_addrs(10'h020, 3);
    check_words(10'h020, 3);
    if (wcyc_log.size() == 3) chk("t1_no_bubble", wcyc_log[2] - wcyc_log[0], 2);

    // Empty packet: timing of header read and rdy
    clear_logs();
    mem[10'h040] = 0;
    base_addr = 10'h040;
    rd_ctrl = 1'b1;
    @(negedge clk); chk("t2_n0_mem_rd", mem_rd, 0);
    @(negedge clk); chk("t2_n1_mem_rd", mem_rd, 1); chk("t2_n1_addr", mem_addr, 10'h040);
    @(negedge clk); chk("t2_n2_rdy", rd_ctrl_rdy, 0);
    @(negedge clk); chk("t2_n3_rdy", rd_ctrl_rdy, 1);
    rd_ctrl = 1'b0;
    tick();
    chk("t2_rdy_drop", rd_ctrl_rdy, 0);
    chk("t2_reads", addr_log.size(), 1);
    chk("t2_words", data_log.size(), 0);

    // Back-pressure: 25 words, consumer stalled for 40 cycles
    out_ready = 1'b0;
    start_pkt(10'h100, 100);
    repeat (40) tick();
    chk("t3_stalled_reads", addr_log.size(), 17);
    chk("t3_valid_held", out_valid, 1);
    out_ready = 1'b1;
    finish_pkt(150);
    check_addrs(10'h100, 25);
    check_words(10'h100, 25);
    if (wcyc_log.size() == 25) chk("t3_no_bubble", wcyc_log[24] - wcyc_log[0], 24);

    // Address wrap at top of buffer
    run_pkt(10'h3FE, 12, 50);
    check_addrs(10'h3FE, 3);
    check_words(10'h3FE, 3);

    // Abort after 5 payload words, then a clean packet
    start_pkt(10'h200, 40);
    k = 0;
    while (data_log.size() < 5 && k < 100) begin
      tick();
      k++;
    end
    chk("t5_reached5", data_log.size() >= 5, 1);
    rd_ctrl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_abort_valid", out_valid, 0);
    chk("t5_abort_mem_rd", mem_rd, 0);
    chk("t5_abort_last", out_last, 0);
    hits = 0;
    repeat (6) begin
      tick();
      if (rd_ctrl_rdy || out_valid || mem_rd) hits++;
    end
    chk("t5_quiet_after_abort", hits, 0);
    run_pkt(10'h280, 8, 50);
    check_addrs(10'h280, 2);
    check_words(10'h280, 2);

    // Reset in the middle of a packet
    start_pkt(10'h100, 100);
    repeat (6) tick();
    reset = 1'b1;
    rd_ctrl = 1'b0;
    tick();
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_mem_rd", mem_rd, 0);
    chk("t7_rst_rdy", rd_ctrl_rdy, 0);
    reset = 1'b0;
    tick();
    run_pkt(10'h020, 10, 50);
    check_words(10'h020, 3);

`ifdef PKT_READER_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_pkt0", pkt_count, 0);
    chk("t6_byte0", byte_count, 0);
    tick();
    run_pkt(10'h300, 10, 50);
    run_pkt(10'h310, 7, 50);
    chk("t6_pkt2", pkt_count, 2);
    chk("t6_byte17", byte_count, 17);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_pkt_rst", pkt_count, 0);
    chk("t6_byte_rst", byte_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
